// File: rtl/fpmult_round_pipe.sv
// fpmult_round_pipe: two-stage rounding back end for a floating-point multiplier.
// Stage 1 takes a normalised mantissa/exponent with guard, round and sticky bits
// and decides whether to round up. Stage 2 applies the increment, folds a
// mantissa carry-out into the exponent and flags exponent overflow.
//
// Handshake: a beat moves across a boundary only on a cycle where the sender's
// valid and the receiver's ready are both 1. A valid beat is held with its data
// stable until taken. in_ready is combinational from pipe occupancy and
// out_ready; out_valid and all output data come straight from flops.
module fpmult_round_pipe #(
    parameter int MW = 23,
    parameter int EW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] NormM,
    input  logic [EW-1:0] NormE,
    input  logic          Sign,
    input  logic          G,
    input  logic          R,
    input  logic          S,
    input  logic [1:0]    Mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] RoundM,
    output logic [EW-1:0] RoundE,
    output logic          SignOut,
    output logic          Inexact,
    output logic          Overflow
);

    // Largest finite biased exponent plus one: 0 followed by EW-1 ones.
    localparam logic [EW-1:0] OVF_THRESH = {1'b0, {(EW-1){1'b1}}};

    localparam logic [1:0] MODE_RNE = 2'd0;
    localparam logic [1:0] MODE_RTZ = 2'd1;
    localparam logic [1:0] MODE_RUP = 2'd2;
    localparam logic [1:0] MODE_RDN = 2'd3;

    // Stage 1 state
    logic          s1_valid_q;
    logic [MW-1:0] s1_m_q;
    logic [EW-1:0] s1_e_q;
    logic          s1_sign_q;
    logic          s1_up_q;
    logic          s1_inexact_q;

    // Stage 2 (output) state
    logic          s2_valid_q;
    logic [MW-1:0] s2_m_q;
    logic [EW-1:0] s2_e_q;
    logic          s2_sign_q;
    logic          s2_inexact_q;
    logic          s2_ovf_q;

    // Next-state values
    logic          s1_up_d;
    logic          s1_inexact_d;
    logic          s2_carry;
    logic [MW-1:0] s2_m_d;
    logic [EW-1:0] s2_e_d;
    logic          s2_ovf_d;

    // Advance control
    logic          s2_load;
    logic          s1_load;

    // Stage 2 takes a new beat (or a bubble) when empty or being drained;
    // stage 1 can refill whenever it is empty or its beat is moving on.
    always_comb begin
        s2_load = !s2_valid_q || out_ready;
        s1_load = !s1_valid_q || s2_load;
    end

    assign in_ready = s1_load;

    // Round-up decision from the incoming beat's mode, sign and G/R/S bits.
    always_comb begin
        s1_inexact_d = G | R | S;
        s1_up_d      = 1'b0;
        case (Mode)
            MODE_RNE: s1_up_d = G & (R | S | NormM[0]);
            MODE_RTZ: s1_up_d = 1'b0;
            MODE_RUP: s1_up_d = ~Sign & s1_inexact_d;
            MODE_RDN: s1_up_d = Sign & s1_inexact_d;
            default:  s1_up_d = 1'b0;
        endcase
    end

    // Increment the mantissa; an all-ones mantissa rounding up wraps to zero
    // and bumps the exponent (modulo 2^EW, no saturation).
    always_comb begin
        s2_carry = s1_up_q & (&s1_m_q);
        if (s2_carry) begin
            s2_m_d = '0;
            s2_e_d = s1_e_q + {{(EW-1){1'b0}}, 1'b1};
        end else begin
            s2_m_d = s1_m_q + {{(MW-1){1'b0}}, s1_up_q};
            s2_e_d = s1_e_q;
        end
        s2_ovf_d = (s2_e_d >= OVF_THRESH);
    end

    // Stage 1 register: capture decision and data for an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_m_q       <= '0;
            s1_e_q       <= '0;
            s1_sign_q    <= 1'b0;
            s1_up_q      <= 1'b0;
            s1_inexact_q <= 1'b0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_m_q       <= NormM;
                s1_e_q       <= NormE;
                s1_sign_q    <= Sign;
                s1_up_q      <= s1_up_d;
                s1_inexact_q <= s1_inexact_d;
            end
        end
    end

    // Stage 2 register: capture the rounded result when stage 1 moves on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q   <= 1'b0;
            s2_m_q       <= '0;
            s2_e_q       <= '0;
            s2_sign_q    <= 1'b0;
            s2_inexact_q <= 1'b0;
            s2_ovf_q     <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_m_q       <= s2_m_d;
                s2_e_q       <= s2_e_d;
                s2_sign_q    <= s1_sign_q;
                s2_inexact_q <= s1_inexact_q;
                s2_ovf_q     <= s2_ovf_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign RoundM    = s2_m_q;
    assign RoundE    = s2_e_q;
    assign SignOut   = s2_sign_q;
    assign Inexact   = s2_inexact_q;
    assign Overflow  = s2_ovf_q;

endmodule
